// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state types and operand-sign helpers for muldiv_unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_FIX,
        ST_DONE
    } md_state_t;

    function automatic logic md_is_signed1(input md_op_t op);
        case (op)
            MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM: md_is_signed1 = 1'b1;
            default:                                    md_is_signed1 = 1'b0;
        endcase
    endfunction

    function automatic logic md_is_signed2(input md_op_t op);
        case (op)
            MD_MUL, MD_MULH, MD_DIV, MD_REM: md_is_signed2 = 1'b1;
            default:                         md_is_signed2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide, one bit per cycle
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic            i_kill,
    output logic            o_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN) + 1;

    md_state_t       state, state_nxt;
    logic [CW-1:0]   cnt;
    md_op_t          op_q;
    logic [XLEN-1:0] acc, sreg, mcand;
    logic            neg_res, neg_rem, fast_q;

    md_op_t          op_in;
    logic            accept, s1, s2, div_zero, div_ovf, fast;
    logic [XLEN-1:0] mag1, mag2, fast_val;

    assign o_ready = (state == ST_IDLE) || (state == ST_DONE);
    assign o_valid = (state == ST_DONE);
    assign accept  = i_valid && o_ready && !i_kill;

    assign op_in    = md_op_t'(i_op);
    assign s1       = md_is_signed1(op_in) && i_op1[XLEN-1];
    assign s2       = md_is_signed2(op_in) && i_op2[XLEN-1];
    assign mag1     = s1 ? -i_op1 : i_op1;
    assign mag2     = s2 ? -i_op2 : i_op2;
    assign div_zero = (i_op2 == '0);
    assign div_ovf  = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                      (i_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (&i_op2);
    assign fast     = op_in[2] && (div_zero || div_ovf);

    // op[1] set within the divide group means a remainder op
    always_comb begin
        fast_val = '0;
        if (div_zero)
            fast_val = op_in[1] ? i_op1 : '1;
        else if (div_ovf)
            fast_val = op_in[1] ? '0 : i_op1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = fast ? ST_FIX : ST_BUSY;
            ST_BUSY: begin
                if (i_kill)
                    state_nxt = ST_IDLE;
                else if (cnt == CW'(XLEN - 1))
                    state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = i_kill ? ST_IDLE : ST_DONE;
            ST_DONE: state_nxt = accept ? (fast ? ST_FIX : ST_BUSY) : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Multiply: {acc,sreg} shifts right as the product; divide: {acc,sreg} shifts left as remainder/quotient
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo, rem, fix_val;

    assign mul_sum   = {1'b0, acc} + (sreg[0] ? {1'b0, mcand} : '0);
    assign div_shift = {acc, sreg[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, mcand};
    assign div_ok    = !div_diff[XLEN];

    assign prod   = {acc, sreg};
    assign prod_s = neg_res ? -prod : prod;
    assign quo    = neg_res ? -sreg : sreg;
    assign rem    = neg_rem ? -acc : acc;

    always_comb begin
        fix_val = '0;
        if (fast_q)
            fix_val = acc;
        else begin
            case (op_q)
                MD_MUL:                       fix_val = prod_s[XLEN-1:0];
                MD_MULH, MD_MULHSU, MD_MULHU: fix_val = prod_s[2*XLEN-1:XLEN];
                MD_DIV, MD_DIVU:              fix_val = quo;
                default:                      fix_val = rem;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= MD_MUL;
            acc      <= '0;
            sreg     <= '0;
            mcand    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            fast_q   <= 1'b0;
            o_result <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q    <= op_in;
                acc     <= fast ? fast_val : '0;
                sreg    <= mag1;
                mcand   <= mag2;
                neg_res <= s1 ^ s2;
                neg_rem <= s1;
                fast_q  <= fast;
                cnt     <= '0;
            end else if (state == ST_BUSY) begin
                cnt <= cnt + CW'(1);
                if (op_q[2]) begin
                    acc  <= div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                    sreg <= {sreg[XLEN-2:0], div_ok};
                end else begin
                    acc  <= mul_sum[XLEN:1];
                    sreg <= {mul_sum[0], sreg[XLEN-1:1]};
                end
            end
            if (state == ST_FIX && !i_kill)
                o_result <= fix_val;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic [2:0]  i_op;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic        i_kill;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] res_q;
    int          edges;
    int          busy_cnt;

    muldiv_unit #(.XLEN(32)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .i_op    (i_op),
        .i_op1   (i_op1),
        .i_op2   (i_op2),
        .i_kill  (i_kill),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_result(o_result)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Accept edge counts as edge 1; returns in the o_valid cycle
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        i_valid = 1'b1;
        i_op    = op;
        i_op1   = a;
        i_op2   = b;
        @(posedge i_clk); #1;
        i_valid  = 1'b0;
        edges    = 1;
        busy_cnt = 0;
        while (!o_valid && edges < 200) begin
            if (!o_ready) busy_cnt++;
            @(posedge i_clk); #1;
            edges++;
        end
        res_q = o_result;
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_kill  = 1'b0;
        i_op    = 3'd0;
        i_op1   = '0;
        i_op2   = '0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", o_result); end
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: ready=%b valid=%b want 1/0", o_ready, o_valid); end
    endtask

    task automatic test_mul_basic;
        run_op(3'b000, 32'd5, 32'd6);
        checks++; if (res_q !== 32'h0000001E) begin errors++; $display("FAIL mul_5x6: got %h want 0000001e", res_q); end
        checks++; if (edges !== 34) begin errors++; $display("FAIL mul_latency: got %0d want 34", edges); end
        checks++; if (busy_cnt !== 33) begin errors++; $display("FAIL mul_ready_low: got %0d want 33", busy_cnt); end
        @(posedge i_clk); #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle: got %b want 0", o_valid); end
    endtask

    task automatic test_mul_sign;
        run_op(3'b000, 32'hFFFFFFFB, 32'd3);
        checks++; if (res_q !== 32'hFFFFFFF1) begin errors++; $display("FAIL mul_neg: got %h want fffffff1", res_q); end
        run_op(3'b001, 32'hFFFFFFFB, 32'd3);
        checks++; if (res_q !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulh_neg: got %h want ffffffff", res_q); end
        run_op(3'b011, 32'hFFFFFFFB, 32'd3);
        checks++; if (res_q !== 32'h00000002) begin errors++; $display("FAIL mulhu: got %h want 00000002", res_q); end
        run_op(3'b010, 32'hFFFFFFFB, 32'd3);
        checks++; if (res_q !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu: got %h want ffffffff", res_q); end
    endtask

    task automatic test_div_sign;
        run_op(3'b100, 32'hFFFFFFFB, 32'd3);
        checks++; if (res_q !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg: got %h want ffffffff", res_q); end
        checks++; if (edges !== 34) begin errors++; $display("FAIL div_latency: got %0d want 34", edges); end
        run_op(3'b110, 32'hFFFFFFFB, 32'd3);
        checks++; if (res_q !== 32'hFFFFFFFE) begin errors++; $display("FAIL rem_neg: got %h want fffffffe", res_q); end
        run_op(3'b101, 32'hFFFFFFFB, 32'd3);
        checks++; if (res_q !== 32'h55555553) begin errors++; $display("FAIL divu: got %h want 55555553", res_q); end
        run_op(3'b111, 32'hFFFFFFFB, 32'd3);
        checks++; if (res_q !== 32'h00000002) begin errors++; $display("FAIL remu: got %h want 00000002", res_q); end
    endtask

    task automatic test_fast_path;
        run_op(3'b100, 32'd6, 32'd0);
        checks++; if (res_q !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_by_zero: got %h want ffffffff", res_q); end
        checks++; if (edges !== 2) begin errors++; $display("FAIL div_by_zero_latency: got %0d want 2", edges); end
        run_op(3'b111, 32'd6, 32'd0);
        checks++; if (res_q !== 32'h00000006) begin errors++; $display("FAIL remu_by_zero: got %h want 00000006", res_q); end
        checks++; if (edges !== 2) begin errors++; $display("FAIL remu_by_zero_latency: got %0d want 2", edges); end
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF);
        checks++; if (res_q !== 32'h80000000) begin errors++; $display("FAIL div_overflow: got %h want 80000000", res_q); end
        checks++; if (edges !== 2) begin errors++; $display("FAIL div_overflow_latency: got %0d want 2", edges); end
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF);
        checks++; if (res_q !== 32'h00000000) begin errors++; $display("FAIL rem_overflow: got %h want 00000000", res_q); end
        checks++; if (edges !== 2) begin errors++; $display("FAIL rem_overflow_latency: got %0d want 2", edges); end
    endtask

    task automatic test_back_to_back;
        @(posedge i_clk); #1;
        i_valid = 1'b1;
        i_op    = 3'b000;
        i_op1   = 32'd5;
        i_op2   = 32'd6;
        @(posedge i_clk); #1;
        // DIVU request stays asserted while the MUL is busy
        i_op  = 3'b101;
        i_op1 = 32'd6;
        i_op2 = 32'd6;
        edges = 1;
        while (!o_valid && edges < 200) begin
            @(posedge i_clk); #1;
            edges++;
        end
        checks++; if (o_result !== 32'h0000001E) begin errors++; $display("FAIL b2b_first: got %h want 0000001e", o_result); end
        checks++; if (edges !== 34) begin errors++; $display("FAIL b2b_first_latency: got %0d want 34", edges); end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL b2b_no_gap: ready=%b want 0", o_ready); end
        edges = 1;
        while (!o_valid && edges < 200) begin
            @(posedge i_clk); #1;
            edges++;
        end
        checks++; if (o_result !== 32'h00000001) begin errors++; $display("FAIL b2b_divu: got %h want 00000001", o_result); end
        checks++; if (edges !== 34) begin errors++; $display("FAIL b2b_second_latency: got %0d want 34", edges); end
        @(posedge i_clk); #1;
    endtask

    task automatic test_kill;
        int seen;
        i_valid = 1'b1;
        i_op    = 3'b000;
        i_op1   = 32'd7;
        i_op2   = 32'd9;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (9) begin @(posedge i_clk); #1; end
        i_kill = 1'b1;
        @(posedge i_clk); #1;
        i_kill = 1'b0;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL kill_ready: got %b want 1", o_ready); end
        seen = 0;
        repeat (40) begin
            if (o_valid) seen++;
            @(posedge i_clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL kill_no_valid: got %0d pulses want 0", seen); end
        checks++; if (o_result !== 32'h00000001) begin errors++; $display("FAIL kill_result_held: got %h want 00000001", o_result); end
        i_valid = 1'b1;
        i_kill  = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_kill  = 1'b0;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL kill_blocks_accept: ready=%b want 1", o_ready); end
    endtask

    task automatic test_reset_mid;
        i_valid = 1'b1;
        i_op    = 3'b101;
        i_op1   = 32'd100;
        i_op2   = 32'd7;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (4) begin @(posedge i_clk); #1; end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", o_valid); end
        checks++; if (o_result !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h want 00000000", o_result); end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        run_op(3'b000, 32'd3, 32'd4);
        checks++; if (res_q !== 32'h0000000C) begin errors++; $display("FAIL after_reset_mul: got %h want 0000000c", res_q); end
        checks++; if (edges !== 34) begin errors++; $display("FAIL after_reset_latency: got %0d want 34", edges); end
    endtask

    initial begin
        test_reset;
        test_mul_basic;
        test_mul_sign;
        test_div_sign;
        test_fast_path;
        test_back_to_back;
        test_kill;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
